// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron trainer.
//   state_t  : controller states
//   sel_w    : width of the readback select for a given input count
//   one      : fixed-point 1.0 for a given number of fractional bits
//   max_v    : largest two's complement value of a given width
//   min_v    : smallest two's complement value of a given width
//   sat_add  : signed add clamped to a given two's complement width
package perceptron_pkg;

    typedef enum logic [2:0] {
        LOAD_W,
        LOAD_N,
        LOAD_X,
        COMPUTE,
        DECIDE,
        UPDATE
    } state_t;

    function automatic int sel_w(input int num_in);
        return $clog2(num_in + 2);
    endfunction

    function automatic longint one(input int frac_w);
        return longint'(1) << frac_w;
    endfunction

    function automatic longint max_v(input int data_w);
        return (longint'(1) << (data_w - 1)) - 1;
    endfunction

    function automatic longint min_v(input int data_w);
        return -(longint'(1) << (data_w - 1));
    endfunction

    // Operands are already sign-extended, so a 64-bit sum cannot overflow
    // before the clamp is applied.
    function automatic longint sat_add(input longint a, input longint b,
                                       input int data_w);
        longint s;
        s = a + b;
        if (s > max_v(data_w))
            s = max_v(data_w);
        else if (s < min_v(data_w))
            s = min_v(data_w);
        return s;
    endfunction

endpackage

// File: rtl/perceptron_trainer_if.sv
// Pin bundle of the perceptron trainer.
//   go, update, label, rd_sel, in_val : driven by the host (master)
//   sync, done, busy, classification,
//   converged, out_val                 : driven by the trainer (slave)
interface perceptron_trainer_if #(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 8
);
    logic                        go;
    logic                        update;
    logic                        label;
    logic [$clog2(NUM_IN+2)-1:0] rd_sel;
    logic [DATA_W-1:0]           in_val;
    logic                        sync;
    logic                        done;
    logic                        busy;
    logic                        classification;
    logic                        converged;
    logic [DATA_W-1:0]           out_val;

    modport master (
        output go, update, label, rd_sel, in_val,
        input  sync, done, busy, classification, converged, out_val
    );

    modport slave (
        input  go, update, label, rd_sel, in_val,
        output sync, done, busy, classification, converged, out_val
    );
endinterface

// File: rtl/fxp_sat_mult.sv
// Combinational fixed-point multiplier.
//   a, b : signed DATA_W operands with FRAC_W fractional bits
//   p    : (a*b) >>> FRAC_W, clamped to the signed DATA_W range
module fxp_sat_mult
    import perceptron_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 3
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] p
);
    localparam logic signed [2*DATA_W-1:0] MAXP = (2*DATA_W)'(max_v(DATA_W));
    localparam logic signed [2*DATA_W-1:0] MINP = (2*DATA_W)'(min_v(DATA_W));

    logic signed [2*DATA_W-1:0] full;
    logic signed [2*DATA_W-1:0] shifted;

    // The shift is arithmetic so negative products round toward -inf.
    always_comb begin
        full    = a * b;
        shifted = full >>> FRAC_W;
        if (shifted > MAXP)
            p = MAXP[DATA_W-1:0];
        else if (shifted < MINP)
            p = MINP[DATA_W-1:0];
        else
            p = shifted[DATA_W-1:0];
    end
endmodule

// File: rtl/perceptron_trainer.sv
// Serially loaded perceptron with on-line training.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : slave side of perceptron_trainer_if (go/sync loading,
//                update/label training control, status and readback)
// Weights w[0..NUM_IN] (w[0] is the bias), rate and samples are loaded one
// word per accepted go. A single saturating multiplier is time-shared
// between the dot product (COMPUTE) and the weight update (UPDATE).
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int NUM_IN   = 4,
    parameter int DATA_W   = 8,
    parameter int FRAC_W   = 3,
    parameter int MAX_ITER = 3
) (
    input logic                 clk,
    input logic                 reset,
    perceptron_trainer_if.slave bus
);
    localparam int SEL_W  = sel_w(NUM_IN);
    localparam int IDX_W  = $clog2(NUM_IN + 1);
    localparam int ITER_W = $clog2(MAX_ITER + 1);
    localparam logic signed [DATA_W-1:0] ONE = DATA_W'(one(FRAC_W));

    state_t                    state;
    logic signed [DATA_W-1:0]  w [0:NUM_IN];
    logic signed [DATA_W-1:0]  x [0:NUM_IN-1];
    logic signed [DATA_W-1:0]  x_ext [0:NUM_IN];
    logic signed [DATA_W-1:0]  rate;
    logic signed [DATA_W-1:0]  acc;
    logic [IDX_W-1:0]          idx;
    logic [ITER_W-1:0]         iter;
    logic                      done_r;
    logic                      class_r;
    logic                      conv_r;

    logic signed [DATA_W-1:0]  mult_a;
    logic signed [DATA_W-1:0]  mult_b;
    logic signed [DATA_W-1:0]  prod;
    logic signed [DATA_W-1:0]  acc_next;
    logic signed [DATA_W-1:0]  w_next;
    logic                      class_now;
    logic                      match;

    // x_ext[0] is the constant 1.0 input that trains the bias.
    always_comb begin
        x_ext[0] = ONE;
        for (int i = 1; i <= NUM_IN; i++)
            x_ext[i] = x[i-1];
    end

    // COMPUTE multiplies w[i]*x[i]; UPDATE multiplies rate*x[i].
    always_comb begin
        mult_a = (state == UPDATE) ? rate : w[idx];
        mult_b = x_ext[idx];
    end

    fxp_sat_mult #(
        .DATA_W(DATA_W),
        .FRAC_W(FRAC_W)
    ) u_mult (
        .a(mult_a),
        .b(mult_b),
        .p(prod)
    );

    // Saturating accumulate and the label-directed weight step.
    always_comb begin
        acc_next  = DATA_W'(sat_add(longint'(acc), longint'(prod), DATA_W));
        w_next    = bus.label
                    ? DATA_W'(sat_add(longint'(w[idx]), longint'(prod), DATA_W))
                    : DATA_W'(sat_add(longint'(w[idx]), -longint'(prod), DATA_W));
        class_now = !acc[DATA_W-1] && (acc != '0);
        match     = (class_now == bus.label);
    end

    // Controller: loading, dot product, decision and update passes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= LOAD_W;
            rate    <= '0;
            acc     <= '0;
            idx     <= '0;
            iter    <= '0;
            done_r  <= 1'b0;
            class_r <= 1'b0;
            conv_r  <= 1'b0;
            for (int i = 0; i <= NUM_IN; i++)
                w[i] <= '0;
            for (int i = 0; i < NUM_IN; i++)
                x[i] <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                LOAD_W: begin
                    if (bus.go) begin
                        w[idx] <= bus.in_val;
                        if (idx == IDX_W'(NUM_IN)) begin
                            idx   <= '0;
                            state <= LOAD_N;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                LOAD_N: begin
                    if (bus.go) begin
                        rate  <= bus.in_val;
                        idx   <= IDX_W'(1);
                        state <= LOAD_X;
                    end
                end
                LOAD_X: begin
                    if (bus.go) begin
                        for (int i = 1; i <= NUM_IN; i++)
                            if (idx == IDX_W'(i))
                                x[i-1] <= bus.in_val;
                        if (idx == IDX_W'(NUM_IN)) begin
                            acc   <= w[0];
                            iter  <= '0;
                            idx   <= IDX_W'(1);
                            state <= COMPUTE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                COMPUTE: begin
                    acc <= acc_next;
                    if (idx == IDX_W'(NUM_IN))
                        state <= DECIDE;
                    else
                        idx <= idx + IDX_W'(1);
                end
                DECIDE: begin
                    class_r <= class_now;
                    if (!bus.update) begin
                        conv_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= LOAD_N;
                    end else if (match || iter == ITER_W'(MAX_ITER)) begin
                        conv_r <= match;
                        done_r <= 1'b1;
                        state  <= LOAD_N;
                    end else begin
                        idx   <= '0;
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    w[idx] <= w_next;
                    if (idx == IDX_W'(NUM_IN)) begin
                        // w[0] was rewritten on the first UPDATE cycle, so
                        // the register already holds the new bias here.
                        acc   <= w[0];
                        iter  <= iter + ITER_W'(1);
                        idx   <= IDX_W'(1);
                        state <= COMPUTE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: state <= LOAD_W;
            endcase
        end
    end

    // Status outputs; sync mirrors an accepted go in a load state.
    always_comb begin
        bus.sync = bus.go && (state == LOAD_W || state == LOAD_N ||
                              state == LOAD_X);
        bus.busy = (state == COMPUTE || state == DECIDE || state == UPDATE);
        bus.done           = done_r;
        bus.classification = class_r;
        bus.converged      = conv_r;
    end

    // Readback: weights, then the accumulator, zero for unused selects.
    always_comb begin
        bus.out_val = '0;
        for (int i = 0; i <= NUM_IN; i++)
            if (bus.rd_sel == SEL_W'(i))
                bus.out_val = w[i];
        if (bus.rd_sel == SEL_W'(NUM_IN + 1))
            bus.out_val = acc;
    end
endmodule

// File: doc/perceptron_trainer.md
Name: perceptron_trainer

Overview:
Parametrised successor to the team's 3-weight perceptron. Holds NUM_IN+1 signed fixed-point weights (w0 is the bias) and classifies a serially loaded sample with one time-shared saturating multiplier-accumulator. When update is requested and the result mismatches label, it repeatedly applies the perceptron rule and re-classifies until the result is correct or MAX_ITER passes are used. It sits behind the same go/sync serial-load pin interface as the existing block.

Parameters:
NUM_IN, 4, number of sample inputs; must be >= 1.
DATA_W, 8, width of weights, samples, rate and accumulator, two's complement.
FRAC_W, 3, fractional bits; 1.0 = 1<<FRAC_W; must be < DATA_W-1.
MAX_ITER, 3, maximum update passes per sample; must be >= 1.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
go  in  1  accept in_val in a load state
update  in  1  enable training for the current sample; sampled in DECIDE
label  in  1  desired class (1 = positive); sampled in DECIDE
rd_sel  in  $clog2(NUM_IN+2)  readback select: 0..NUM_IN = w[i], NUM_IN+1 = accumulator, others = 0
in_val  in  DATA_W  serial data word
sync  out  1  high in the cycle a word is accepted
done  out  1  one-cycle pulse: sample finished
busy  out  1  high in COMPUTE, DECIDE, UPDATE
classification  out  1  registered result of the last DECIDE
converged  out  1  registered; classification == label at final DECIDE (0 when update=0)
out_val  out  DATA_W  combinational readback mux

Behaviour:
- Reset (async, high): state LOAD_W, all weights, rate, samples, accumulator, index and iteration counters = 0. done, classification and converged = 0. Reset mid-operation aborts with no partial writeback.
- Arithmetic:
  - mul(a,b) = full 2*DATA_W signed product, arithmetic shift right by FRAC_W, clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - add is a signed add clamped to the same range.
  - No wrap-around anywhere.
- States:
  - LOAD_W: each go stores in_val into w[idx] and pulses sync. After w[NUM_IN] is stored -> LOAD_N.
  - LOAD_N: go stores the rate n and pulses sync -> LOAD_X.
  - LOAD_X: each go stores x[idx] (1..NUM_IN) and pulses sync. After the last word -> COMPUTE, with acc <= w0 and iter <= 0.
  - COMPUTE: NUM_IN cycles, one per i = 1..NUM_IN, acc <= add(acc, mul(w[i], x[i])) -> DECIDE.
  - DECIDE (1 cycle): register classification = (acc > 0, signed) and compute match = (classification == label).
    - If update=0: converged <= 0, done the next cycle, -> LOAD_N.
    - If update=1 and (match or iter == MAX_ITER): converged <= match, done the next cycle, -> LOAD_N.
    - Otherwise -> UPDATE.
  - UPDATE: NUM_IN+1 cycles, i = 0..NUM_IN, with x0 = 1.0. Add mul(n, x[i]) to w[i] if label = 1, subtract it if label = 0 (both saturating). Then iter++, acc <= w0 (updated value), -> COMPUTE.
- go is ignored while busy. Weights persist across samples; only a reset or a new LOAD_W sequence changes them externally. LOAD_W is entered only from reset.
- Latency with no update: done is high exactly NUM_IN+2 cycles after the cycle the last x is accepted. Each update pass adds 2*NUM_IN+2 cycles.
- update and label must be stable from the last x accept through done.

Decomposition:
- perceptron_pkg holds:
  - state enum {LOAD_W, LOAD_N, LOAD_X, COMPUTE, DECIDE, UPDATE}
  - sat_add function
  - derived constants SEL_W, ONE = 1<<FRAC_W, MAXV, MINV
- One sub-module, fxp_sat_mult: combinational multiply, shift and clamp, parametrised by DATA_W and FRAC_W, shared by COMPUTE and UPDATE through operand muxes.

Test Plan:
Bench settings: NUM_IN=2, DATA_W=8, FRAC_W=3, MAX_ITER=3.
1. Load w = {0, 8, 8}, n = 4, x = {8, 8}, update=1, label=1 -> classification=1, converged=1, acc readback = 16, done 4 cycles after the last x, weights unchanged.
2. Load w = {0, -8, 0}, n = 8, x = {8, 0}, label=1, update=1 -> first DECIDE gives 0; after one pass w = {8, 0, 0}, acc = 8, classification=1, converged=1, one done pulse.
3. Saturation: w = {127, 127, 0}, x = {127, 0}, update=0 -> acc = 127, classification=1, converged=0, no wrap.
4. Non-convergence: w = {100, 0, 0}, n = 1, x = {0, 0}, label=0, update=1 -> three passes, w0 readback = 97, classification=1, converged=0, done after MAX_ITER passes.
5. go asserted during COMPUTE/UPDATE -> no sync and no register change. After done, the next go is taken as n (LOAD_N) with no reload of weights.
6. Assert reset mid-UPDATE -> all readbacks 0, busy=0, state LOAD_W; the next go is stored into w0.
